// File: rtl/config_frame_sequencer.sv
// Packs a word stream into column frames and strobes each frame into its (row, block) word line,
// walking block-major within row across the whole configuration array.
module config_frame_sequencer #(
    parameter int unsigned ROWS        = 19,
    parameter int unsigned BLOCKS      = 9,
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned WR_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_start,
    input  logic                          io_inValid,
    input  logic [WORD_W-1:0]             io_inData,
    output logic                          io_inReady,
    output logic [5:0]                    io_rAddr,
    output logic [3:0]                    io_bAddr,
    output logic [WORD_W*FRAME_WORDS-1:0] io_colData,
    output logic                          io_wrEn,
    output logic                          io_busy,
    output logic                          io_done
);

    localparam int unsigned ColW  = WORD_W * FRAME_WORDS;
    localparam int unsigned WcntW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned TmrW  = $clog2(WR_CYCLES + 1);

    localparam logic [WcntW-1:0] WcntLast = WcntW'(FRAME_WORDS - 1);
    localparam logic [TmrW-1:0]  TmrLast  = TmrW'(WR_CYCLES - 1);
    localparam logic [5:0]       RowLast  = 6'(ROWS - 1);
    localparam logic [3:0]       BlkLast  = 4'(BLOCKS - 1);
    localparam logic [5:0]       NoRow    = 6'h3F;

    typedef enum logic [2:0] {StIdle, StLoad, StWrite, StHold, StDone} state_e;

    state_e           state_q;
    logic [5:0]       row_q;
    logic [3:0]       blk_q;
    logic [WcntW-1:0] wcnt_q;
    logic [TmrW-1:0]  tmr_q;
    logic [ColW-1:0]  col_q;
    logic [5:0]       raddr_q;
    logic [3:0]       baddr_q;
    logic             wren_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            blk_q   <= '0;
            wcnt_q  <= '0;
            tmr_q   <= '0;
            col_q   <= '0;
            raddr_q <= NoRow;
            baddr_q <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (io_start) begin
                        state_q <= StLoad;
                        row_q   <= '0;
                        blk_q   <= '0;
                        wcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StLoad: begin
                    if (io_inValid) begin
                        // First word of the frame ends up in the top lane.
                        col_q <= {col_q[ColW-WORD_W-1:0], io_inData};
                        if (wcnt_q == WcntLast) begin
                            wcnt_q  <= '0;
                            tmr_q   <= '0;
                            state_q <= StWrite;
                            wren_q  <= 1'b1;
                            raddr_q <= row_q;
                            baddr_q <= blk_q;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (tmr_q == TmrLast) begin
                        tmr_q   <= '0;
                        wren_q  <= 1'b0;
                        state_q <= StHold;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StHold: begin
                    // Addresses stay put this cycle for word-line hold time.
                    raddr_q <= NoRow;
                    baddr_q <= '0;
                    if (blk_q != BlkLast) begin
                        blk_q   <= blk_q + 1'b1;
                        state_q <= StLoad;
                    end else if (row_q != RowLast) begin
                        blk_q   <= '0;
                        row_q   <= row_q + 1'b1;
                        state_q <= StLoad;
                    end else begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign io_inReady = (state_q == StLoad);
    assign io_rAddr   = raddr_q;
    assign io_bAddr   = baddr_q;
    assign io_colData = col_q;
    assign io_wrEn    = wren_q;
    assign io_busy    = busy_q;
    assign io_done    = done_q;

endmodule
